// File: rtl/write_buffer_arbiter.sv
// Round-robin arbiter sharing one write_axi_buffer between dcache writeback (req0) and the
// uncached store path (req1). Optional perf counters: define WBUF_ARB_PERF_CNT_EN.
module write_buffer_arbiter #(
    parameter int unsigned LINE_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_uncached,
    input  logic [31:0]            req0_addr,
    input  logic [2:0]             req0_size,
    input  logic [3:0]             req0_wstrb,
    input  logic [31:0]            req0_data,
    input  logic [LINE_SIZE*8-1:0] req0_line,
    output logic                   req0_done,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_uncached,
    input  logic [31:0]            req1_addr,
    input  logic [2:0]             req1_size,
    input  logic [3:0]             req1_wstrb,
    input  logic [31:0]            req1_data,
    input  logic [LINE_SIZE*8-1:0] req1_line,
    output logic                   req1_done,

    output logic                   wbuf_en,
    output logic                   wbuf_uncached,
    output logic [31:0]            wbuf_addr,
    output logic [2:0]             wbuf_size,
    output logic [3:0]             wbuf_wstrb,
    output logic [31:0]            wbuf_data,
    output logic [LINE_SIZE*8-1:0] wbuf_line,
    input  logic                   wbuf_empty,

    input  logic [31:0]            query_addr,
    output logic                   query_hit
`ifdef WBUF_ARB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_grant0,
    output logic [31:0]            perf_grant1,
    output logic [31:0]            perf_busy_cycles
`endif
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [31:0] LineMask = ~(32'(LINE_SIZE) - 32'd1);
    localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] owner_addr_q, owner_addr_d;
    logic        owner_uncached_q, owner_uncached_d;
    logic        last_grant_q, last_grant_d;

    logic        grant;
    logic        winner;
    logic        cmp_active;
    logic        cmp_uncached;
    logic [31:0] cmp_addr;

    always_comb begin
        grant  = (state_q == StIdle) && wbuf_empty && (req0_valid || req1_valid);
        // Tie goes to whoever did not win last; a lone requester wins outright.
        winner = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

        state_d          = state_q;
        owner_d          = owner_q;
        owner_addr_d     = owner_addr_q;
        owner_uncached_d = owner_uncached_q;
        last_grant_d     = last_grant_q;

        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        req0_done     = 1'b0;
        req1_done     = 1'b0;
        wbuf_en       = 1'b0;
        wbuf_uncached = 1'b0;
        wbuf_addr     = '0;
        wbuf_size     = '0;
        wbuf_wstrb    = '0;
        wbuf_data     = '0;
        wbuf_line     = '0;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    wbuf_en = 1'b1;
                    if (winner) begin
                        req1_ready    = 1'b1;
                        wbuf_uncached = req1_uncached;
                        wbuf_addr     = req1_addr;
                        wbuf_size     = req1_size;
                        wbuf_wstrb    = req1_wstrb;
                        wbuf_data     = req1_data;
                        wbuf_line     = req1_line;
                    end else begin
                        req0_ready    = 1'b1;
                        wbuf_uncached = req0_uncached;
                        wbuf_addr     = req0_addr;
                        wbuf_size     = req0_size;
                        wbuf_wstrb    = req0_wstrb;
                        wbuf_data     = req0_data;
                        wbuf_line     = req0_line;
                    end
                    state_d          = StBusy;
                    owner_d          = winner;
                    owner_addr_d     = wbuf_addr;
                    owner_uncached_d = wbuf_uncached;
                    last_grant_d     = winner;
                end
            end
            StBusy: begin
                if (wbuf_empty) begin
                    state_d   = StIdle;
                    req0_done = ~owner_q;
                    req1_done = owner_q;
                end
            end
        endcase
    end

    // Hazard window covers the grant cycle (winner payload) and the whole BUSY phase.
    always_comb begin
        cmp_active   = (state_q == StBusy) || grant;
        cmp_addr     = (state_q == StBusy) ? owner_addr_q : wbuf_addr;
        cmp_uncached = (state_q == StBusy) ? owner_uncached_q : wbuf_uncached;
        query_hit    = cmp_active &&
                       (((query_addr ^ cmp_addr) & (cmp_uncached ? WordMask : LineMask)) == 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            owner_q          <= 1'b0;
            owner_addr_q     <= '0;
            owner_uncached_q <= 1'b0;
            last_grant_q     <= 1'b1;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            owner_addr_q     <= owner_addr_d;
            owner_uncached_q <= owner_uncached_d;
            last_grant_q     <= last_grant_d;
        end
    end

`ifdef WBUF_ARB_PERF_CNT_EN
    logic [31:0] perf_grant0_q, perf_grant0_d;
    logic [31:0] perf_grant1_q, perf_grant1_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_grant0_d = perf_grant0_q;
        perf_grant1_d = perf_grant1_q;
        perf_busy_d   = perf_busy_q;
        if (grant && !winner) perf_grant0_d = perf_grant0_q + 32'd1;
        if (grant && winner)  perf_grant1_d = perf_grant1_q + 32'd1;
        if (state_q == StBusy) perf_busy_d  = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant0_q <= '0;
            perf_grant1_q <= '0;
            perf_busy_q   <= '0;
        end else begin
            perf_grant0_q <= perf_grant0_d;
            perf_grant1_q <= perf_grant1_d;
            perf_busy_q   <= perf_busy_d;
        end
    end

    assign perf_grant0      = perf_grant0_q;
    assign perf_grant1      = perf_grant1_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_write_buffer_arbiter.sv
// Directed self-checking bench for write_buffer_arbiter (LINE_SIZE=16).
module tb_write_buffer_arbiter;

    localparam int unsigned LINE_SIZE = 16;
    localparam int unsigned LW = LINE_SIZE * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, req0_uncached, req0_done;
    logic [31:0]   req0_addr, req0_data;
    logic [2:0]    req0_size;
    logic [3:0]    req0_wstrb;
    logic [LW-1:0] req0_line;
    logic          req1_valid, req1_ready, req1_uncached, req1_done;
    logic [31:0]   req1_addr, req1_data;
    logic [2:0]    req1_size;
    logic [3:0]    req1_wstrb;
    logic [LW-1:0] req1_line;
    logic          wbuf_en, wbuf_uncached, wbuf_empty;
    logic [31:0]   wbuf_addr, wbuf_data;
    logic [2:0]    wbuf_size;
    logic [3:0]    wbuf_wstrb;
    logic [LW-1:0] wbuf_line;
    logic [31:0]   query_addr;
    logic          query_hit;
`ifdef WBUF_ARB_PERF_CNT_EN
    logic [31:0]   perf_grant0, perf_grant1, perf_busy_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int exp_g0 = 0;
    int exp_g1 = 0;
    int exp_busy = 0;

    always #5 clk = ~clk;

    write_buffer_arbiter #(.LINE_SIZE(LINE_SIZE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_uncached(req0_uncached),
        .req0_addr(req0_addr), .req0_size(req0_size), .req0_wstrb(req0_wstrb),
        .req0_data(req0_data), .req0_line(req0_line), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_uncached(req1_uncached),
        .req1_addr(req1_addr), .req1_size(req1_size), .req1_wstrb(req1_wstrb),
        .req1_data(req1_data), .req1_line(req1_line), .req1_done(req1_done),
        .wbuf_en(wbuf_en), .wbuf_uncached(wbuf_uncached), .wbuf_addr(wbuf_addr),
        .wbuf_size(wbuf_size), .wbuf_wstrb(wbuf_wstrb), .wbuf_data(wbuf_data),
        .wbuf_line(wbuf_line), .wbuf_empty(wbuf_empty),
        .query_addr(query_addr), .query_hit(query_hit)
`ifdef WBUF_ARB_PERF_CNT_EN
        ,
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_busy_cycles(perf_busy_cycles)
`endif
    );

    task automatic chk(input string tag, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [LW-1:0] line_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h1111_1111, ~a ^ 32'h2222_2222};
    endfunction

    task automatic drive_req(input int who, input logic v, input logic unc, input logic [31:0] a);
        if (who == 0) begin
            req0_valid = v; req0_uncached = unc; req0_addr = a;
            req0_size = unc ? 3'd2 : 3'd4; req0_wstrb = unc ? 4'hF : 4'h3;
            req0_data = a ^ 32'h5A5A_0000; req0_line = line_of(a);
        end else begin
            req1_valid = v; req1_uncached = unc; req1_addr = a;
            req1_size = unc ? 3'd1 : 3'd4; req1_wstrb = unc ? 4'hC : 4'h3;
            req1_data = a ^ 32'h0000_A5A5; req1_line = line_of(a);
        end
    endtask

    // Grant in the current cycle, then enter BUSY with the buffer reporting non-empty.
    task automatic start(input int who, input logic unc, input logic [31:0] a);
        logic [2:0] sz;
        logic [3:0] st;
        logic [31:0] dt;
        sz = (who == 0) ? (unc ? 3'd2 : 3'd4) : (unc ? 3'd1 : 3'd4);
        st = (who == 0) ? (unc ? 4'hF : 4'h3) : (unc ? 4'hC : 4'h3);
        dt = (who == 0) ? (a ^ 32'h5A5A_0000) : (a ^ 32'h0000_A5A5);
        drive_req(who, 1'b1, unc, a);
        settle();
        chk("grant_en", wbuf_en === 1'b1);
        chk("grant_ready", {req0_ready, req1_ready} === ((who == 0) ? 2'b10 : 2'b01));
        chk("grant_done_quiet", {req0_done, req1_done} === 2'b00);
        chk("grant_addr", wbuf_addr === a);
        chk("grant_unc", wbuf_uncached === unc);
        chk("grant_size", wbuf_size === sz);
        chk("grant_wstrb", wbuf_wstrb === st);
        chk("grant_data", wbuf_data === dt);
        chk("grant_line", wbuf_line === line_of(a));
        if (who == 0) exp_g0++; else exp_g1++;
        tick();
        drive_req(who, 1'b0, unc, a);
        wbuf_empty = 1'b0;
        settle();
        chk("busy_en", wbuf_en === 1'b0);
        chk("busy_ready", {req0_ready, req1_ready} === 2'b00);
        chk("busy_payload_zero", {wbuf_addr, wbuf_data, wbuf_line} === 192'd0);
        chk("busy_done", {req0_done, req1_done} === 2'b00);
    endtask

    task automatic finish_busy(input int who, input int busy);
        wbuf_empty = 1'b1;
        settle();
        chk("done_pulse", {req0_done, req1_done} === ((who == 0) ? 2'b10 : 2'b01));
        chk("done_no_ready", {req0_ready, req1_ready} === 2'b00);
        exp_busy += busy;
        tick();
        settle();
        chk("done_cleared", {req0_done, req1_done} === 2'b00);
    endtask

    task automatic txn(input int who, input logic unc, input logic [31:0] a, input int hold);
        start(who, unc, a);
        repeat (hold) tick();
        finish_busy(who, hold + 1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_req(0, 1'b0, 1'b0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0);
        wbuf_empty = 1'b1;
        query_addr = 32'd0;
        settle();
        chk("rst_outputs",
            {wbuf_en, req0_ready, req1_ready, req0_done, req1_done, query_hit} === 6'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_outputs", {wbuf_en, req0_ready, req1_ready, req0_done, req1_done,
            query_hit, wbuf_addr} === 38'd0);
        exp_g0 = 0;
        exp_g1 = 0;
        exp_busy = 0;
`ifdef WBUF_ARB_PERF_CNT_EN
        chk("perf_rst", {perf_grant0, perf_grant1, perf_busy_cycles} === 96'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        apply_reset();

        // Single cached writeback, buffer busy for 10 cycles.
        txn(0, 1'b0, 32'h1000_0040, 10);

        // Hazard query against a cached line and an uncached word.
        query_addr = 32'h1000_004C;
        drive_req(0, 1'b1, 1'b0, 32'h1000_0040);
        settle();
        chk("query_grant_cycle", query_hit === 1'b1);
        start(0, 1'b0, 32'h1000_0040);
        chk("query_line_hit", query_hit === 1'b1);
        query_addr = 32'h1000_0050;
        settle();
        chk("query_next_line", query_hit === 1'b0);
        query_addr = 32'h1000_003F;
        settle();
        chk("query_prev_line", query_hit === 1'b0);
        tick();
        finish_busy(0, 2);
        query_addr = 32'h1000_0040;
        settle();
        chk("query_idle", query_hit === 1'b0);
        start(1, 1'b1, 32'hBFD0_0000);
        query_addr = 32'hBFD0_0004;
        settle();
        chk("query_unc_next_word", query_hit === 1'b0);
        query_addr = 32'hBFD0_0003;
        settle();
        chk("query_unc_same_word", query_hit === 1'b1);
        tick();
        finish_busy(1, 2);

        // Both requesters hammering from reset: strict alternation 0,1,0,1.
        apply_reset();
        drive_req(0, 1'b1, 1'b0, 32'h0000_1000);
        drive_req(1, 1'b1, 1'b1, 32'h0000_2004);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_en", wbuf_en === 1'b1);
            chk("rr_ready", {req0_ready, req1_ready} === ((k % 2 == 0) ? 2'b10 : 2'b01));
            chk("rr_addr", wbuf_addr === ((k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2004));
            tick();
            drive_req(k % 2, 1'b0, (k % 2) == 1, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2004);
            wbuf_empty = 1'b0;
            settle();
            chk("rr_busy_no_grant", {req0_ready, req1_ready, wbuf_en} === 3'b000);
            tick();
            tick();
            finish_busy(k % 2, 3);
            if (k < 3) begin
                drive_req(k % 2, 1'b1, (k % 2) == 1,
                          (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2004);
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end

        // Request while the buffer is busy from elsewhere waits for empty.
        apply_reset();
        wbuf_empty = 1'b0;
        drive_req(1, 1'b1, 1'b1, 32'h3000_0008);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("wait_empty", {wbuf_en, req0_ready, req1_ready} === 3'b000);
            tick();
        end
        wbuf_empty = 1'b1;
        start(1, 1'b1, 32'h3000_0008);
        tick();
        tick();
        finish_busy(1, 3);

        // Reset in the middle of BUSY: no done, and req0 regains tie priority.
        start(0, 1'b0, 32'h2000_0000);
        query_addr = 32'h2000_0000;
        tick();
        rst = 1'b1;
        wbuf_empty = 1'b1;
        settle();
        chk("midrst_quiet", {req0_done, req1_done, wbuf_en, query_hit} === 4'b0000);
        tick();
        rst = 1'b0;
        settle();
        chk("midrst_no_done", {req0_done, req1_done} === 2'b00);
        drive_req(0, 1'b1, 1'b0, 32'h2000_0000);
        drive_req(1, 1'b1, 1'b1, 32'h2000_0100);
        settle();
        chk("midrst_prio", {req0_ready, req1_ready} === 2'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wbuf_empty = 1'b0;
        tick();
        finish_busy(0, 2);

        // Counter workout: 5 req0 grants, 3 req1 grants.
        apply_reset();
        for (int i = 0; i < 5; i++) txn(0, i[0], 32'h4000_0000 + 32'(i * 16), i + 1);
        for (int i = 0; i < 3; i++) txn(1, 1'b1, 32'h5000_0000 + 32'(i * 4), i + 2);
`ifdef WBUF_ARB_PERF_CNT_EN
        chk("perf_grant0", perf_grant0 === 32'(exp_g0));
        chk("perf_grant1", perf_grant1 === 32'(exp_g1));
        chk("perf_busy", perf_busy_cycles === 32'(exp_busy));
`endif
        chk("final_idle", {wbuf_en, req0_done, req1_done} === 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
